// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer for a rate-1/2, K=3 convolutional encoder core
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    serial bit handshake, in_ready is combinational
//   in_data, in_last     data bit and end-of-frame marker
//   enc_clr              clears the encoder core shift state (after reset, during GAP)
//   enc_load, enc_bit    load strobe and bit presented to the core
//   enc_pair             core output, valid the cycle after enc_load
//   code_out/code_valid  serial code stream, code_first marks pair bit [0]
//   frame_start/end      first / last code bit of a frame
//   frame_trunc          frame was cut at MAX_FRAME
//   busy                 controller is not idle
module conv_frame_ctrl #(
    parameter int MAX_FRAME  = 1024,
    parameter int TAIL_LEN   = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_data,
    input  logic       in_last,
    output logic       enc_clr,
    output logic       enc_load,
    output logic       enc_bit,
    input  logic [1:0] enc_pair,
    output logic       code_out,
    output logic       code_valid,
    output logic       code_first,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_trunc,
    output logic       busy
);
    localparam int CW = $clog2(MAX_FRAME + 1);
    localparam int TW = $clog2(TAIL_LEN + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, DATA, TAIL, FLUSH, GAP} state_t;

    state_t        state;
    logic          phase, rst_seen;
    logic [CW-1:0] frame_cnt;
    logic [TW-1:0] tail_cnt;
    logic [GW-1:0] gap_cnt;
    logic          accept, tail_ld, last_ld, cnt_full;
    logic          cap, st_d1, lt_d1, sec, lt_d2, hi;

    // rst_seen blocks accepts until the post-reset clear cycle has been issued
    assign in_ready = (state == IDLE || state == DATA) && !phase && !reset && !enc_clr && !rst_seen;
    assign accept   = in_valid && in_ready;
    assign tail_ld  = state == TAIL && !phase;
    assign last_ld  = tail_ld && tail_cnt == TW'(TAIL_LEN - 1);
    assign enc_load = accept || tail_ld;
    assign enc_bit  = accept && in_data;
    assign busy     = state != IDLE;
    // the bit being accepted brings the frame to MAX_FRAME bits
    assign cnt_full = frame_cnt == CW'(MAX_FRAME - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= 1'b0;
            rst_seen    <= 1'b1;
            enc_clr     <= 1'b0;
            frame_cnt   <= '0;
            tail_cnt    <= '0;
            gap_cnt     <= '0;
            frame_trunc <= 1'b0;
        end else begin
            rst_seen <= 1'b0;
            phase    <= enc_load;
            enc_clr  <= rst_seen || (state == FLUSH && frame_end) ||
                        (state == GAP && gap_cnt != GW'(GAP_CYCLES - 1));
            case (state)
                IDLE: if (accept) begin
                    frame_cnt   <= CW'(1);
                    tail_cnt    <= '0;
                    frame_trunc <= !in_last && MAX_FRAME == 1;
                    state       <= (in_last || MAX_FRAME == 1) ? TAIL : DATA;
                end
                DATA: if (accept) begin
                    if (frame_cnt != CW'(MAX_FRAME)) frame_cnt <= frame_cnt + 1'b1;
                    if (in_last || cnt_full) begin
                        frame_trunc <= !in_last;
                        state       <= TAIL;
                    end
                end
                TAIL: if (tail_ld) begin
                    tail_cnt <= tail_cnt + 1'b1;
                    if (last_ld) state <= FLUSH;
                end
                FLUSH: if (frame_end) begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // cap marks the cycle enc_pair is valid; sec marks the following cycle,
    // when the held pair bit [1] goes out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap         <= 1'b0;
            st_d1       <= 1'b0;
            lt_d1       <= 1'b0;
            sec         <= 1'b0;
            lt_d2       <= 1'b0;
            hi          <= 1'b0;
            code_out    <= 1'b0;
            code_valid  <= 1'b0;
            code_first  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            cap         <= enc_load;
            st_d1       <= accept && state == IDLE;
            lt_d1       <= last_ld;
            sec         <= cap;
            lt_d2       <= lt_d1;
            hi          <= cap ? enc_pair[1] : hi;
            code_out    <= cap ? enc_pair[0] : sec && hi;
            code_valid  <= cap || sec;
            code_first  <= cap;
            frame_start <= cap && st_d1;
            frame_end   <= sec && lt_d2;
        end
    end
endmodule
